sensor_value_solver: RTL
========================

Name: sensor_value_solver

Overview:
Inverse of the temperature calculator, which computes temperature = factoryBaseTemp + factoryTempCoef * tempSensorValue. Given a target temperature and the factory calibration pair, this block finds the 4-bit sensor value that produces that temperature. It uses a multi-cycle repeated-subtraction FSM. It serves thermostat/alarm logic that must turn a temperature threshold into a raw sensor compare value.

Parameters:
BASE_W, 5, width of factory base temperature
COEF_W, 4, width of factory coefficient and of sensor value
TEMP_W, 8, width of temperature

Ports:
clk  input  1  single system clock, rising edge
rst  input  1  asynchronous, active-high reset
start  input  1  request; sampled only in IDLE
targetTemp  input  TEMP_W  temperature to invert
factotyBaseTemp  input  BASE_W  factory base temperature
factotyTempCoef  input  COEF_W  factory temperature coefficient
busy  output  1  high from the edge after start is accepted until DONE
done  output  1  one-cycle pulse; results valid from this cycle
sensorValue  output  COEF_W  solved sensor value (quotient)
remainder  output  COEF_W  (target - base) mod coef; 0 when exact
exact  output  1  remainder == 0 and error == 0
error  output  2  00 ok, 01 target below base, 10 quotient > 15, 11 coef zero and target != base

Behaviour:
- Reset (async, any time, including mid-operation): state=IDLE, busy=0, done=0, sensorValue=0, remainder=0, exact=0, error=00. Internal regs cleared. No partial result survives.
- States: IDLE, CHECK, DIVIDE, DONE.
- IDLE: on start=1, latch all three inputs, then go to CHECK with busy=1. Edge E0 is the edge that samples start.
- CHECK (edge E1):
  - target < base: error=01 -> DONE.
  - coef==0 and target==base: sensorValue=0, remainder=0 -> DONE.
  - coef==0 and target!=base: error=11 -> DONE.
  - otherwise: rem = target - base (TEMP_W bits, zero-extend base), q=0 -> DIVIDE.
- DIVIDE (one step per edge):
  - rem >= coef and q < 15: rem -= coef, q++.
  - rem >= coef and q == 15: error=10, go to DONE.
  - rem < coef: sensorValue=q, remainder=rem[3:0] -> DONE.
- DONE: done=1 for exactly one cycle, busy=0, then IDLE. On error, sensorValue=0 and remainder=0.
- Latency: the success path sets done at edge E(2+q). The CHECK-detected errors and the coef-zero exact case set done at E1. Overrange sets done at E17.
- Outputs hold their values after done until the next accepted start, and clear when that start is accepted.
- start while busy or in DONE is ignored (no queueing). start held high in IDLE after DONE begins a new solve.
- Arithmetic is unsigned. Inputs change while busy without effect, because the values are latched.

Decomposition:
- Shared header (`include`, Verilog-2001 `define`s): state encodings (2 bits), ERR_OK/ERR_BELOW/ERR_RANGE/ERR_COEF0 codes, widths. The temperature calculator and alarm logic share the same header.
- No sub-module needed. The single-step subtract/compare stays inline in the FSM.

Test Plan:
- base=21, coef=15, target=201, start pulse -> done at E14, sensorValue=12, remainder=0, exact=1, error=00. Re-running the calculator on 12 gives 201.
- base=19, coef=11, target=135 -> done at E12, sensorValue=10, remainder=6, exact=0, error=00.
- base=19, coef=11, target=10 -> done at E1, error=01, sensorValue=0. Then coef=0, target=19 -> sensorValue=0, exact=1. Then coef=0, target=20 -> error=11.
- base=0, coef=1, target=16 -> done at E17, error=10. Then target=15 -> sensorValue=15, exact=1 at E17.
- Start with base=21, coef=15, target=201. Pulse start again at E3 (ignored). Assert rst at E5 (async, mid-DIVIDE) -> all outputs 0 immediately, no done. After release, a new start completes normally.
- Back-to-back: hold start high -> second solve accepted in the IDLE cycle after done. Previous results are held until that acceptance.

Source files
------------

// File: rtl/sensor_value_solver_pkg.sv
// Shared definitions for the sensor value solver: default widths, FSM state encoding
// and the error codes reported on the error output.
package sensor_value_solver_pkg;

   localparam int BASE_W = 5;
   localparam int COEF_W = 4;
   localparam int TEMP_W = 8;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      CHECK  = 2'd1,
      DIVIDE = 2'd2,
      DONE   = 2'd3
   } solverState_t;

   localparam logic [1:0] ERR_OK    = 2'b00;
   localparam logic [1:0] ERR_BELOW = 2'b01;
   localparam logic [1:0] ERR_RANGE = 2'b10;
   localparam logic [1:0] ERR_COEF0 = 2'b11;

endpackage

// File: rtl/sensor_value_solver_if.sv
// Request/result bundle of the sensor value solver; master issues solves, slave answers.
interface sensor_value_solver_if
   import sensor_value_solver_pkg::*;
#(
   parameter int BASE_W = sensor_value_solver_pkg::BASE_W,
   parameter int COEF_W = sensor_value_solver_pkg::COEF_W,
   parameter int TEMP_W = sensor_value_solver_pkg::TEMP_W
);

   logic              start;
   logic [TEMP_W-1:0] targetTemp;
   logic [BASE_W-1:0] factotyBaseTemp;
   logic [COEF_W-1:0] factotyTempCoef;
   logic              busy;
   logic              done;
   logic [COEF_W-1:0] sensorValue;
   logic [COEF_W-1:0] remainder;
   logic              exact;
   logic [1:0]        error;

   modport master (
      output start, targetTemp, factotyBaseTemp, factotyTempCoef,
      input  busy, done, sensorValue, remainder, exact, error
   );

   modport slave (
      input  start, targetTemp, factotyBaseTemp, factotyTempCoef,
      output busy, done, sensorValue, remainder, exact, error
   );

endinterface

// File: rtl/sensor_value_solver.sv
// Inverts temperature = base + coef * sensor by repeated subtraction, one step per clock,
// so a temperature threshold can be turned into a raw sensor compare value.
module sensor_value_solver
   import sensor_value_solver_pkg::*;
#(
   parameter int BASE_W = sensor_value_solver_pkg::BASE_W,
   parameter int COEF_W = sensor_value_solver_pkg::COEF_W,
   parameter int TEMP_W = sensor_value_solver_pkg::TEMP_W
) (
   input  logic                  clk,
   input  logic                  rst,
   sensor_value_solver_if.slave  solverBus
);

   solverState_t      state;
   logic [TEMP_W-1:0] targetLatched;
   logic [BASE_W-1:0] baseLatched;
   logic [COEF_W-1:0] coefLatched;
   logic [TEMP_W-1:0] rem;
   logic [COEF_W-1:0] quotient;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state                 <= IDLE;
         targetLatched         <= '0;
         baseLatched           <= '0;
         coefLatched           <= '0;
         rem                   <= '0;
         quotient              <= '0;
         solverBus.busy        <= 1'b0;
         solverBus.done        <= 1'b0;
         solverBus.sensorValue <= '0;
         solverBus.remainder   <= '0;
         solverBus.exact       <= 1'b0;
         solverBus.error       <= ERR_OK;
      end else begin
         case (state)
            IDLE: begin
               solverBus.done <= 1'b0;
               // Previous results stay visible until a new request is actually taken.
               if (solverBus.start) begin
                  targetLatched         <= solverBus.targetTemp;
                  baseLatched           <= solverBus.factotyBaseTemp;
                  coefLatched           <= solverBus.factotyTempCoef;
                  solverBus.busy        <= 1'b1;
                  solverBus.sensorValue <= '0;
                  solverBus.remainder   <= '0;
                  solverBus.exact       <= 1'b0;
                  solverBus.error       <= ERR_OK;
                  state                 <= CHECK;
               end
            end

            CHECK: begin
               if (targetLatched < TEMP_W'(baseLatched)) begin
                  solverBus.error <= ERR_BELOW;
                  solverBus.busy  <= 1'b0;
                  solverBus.done  <= 1'b1;
                  state           <= DONE;
               end else if (coefLatched == '0) begin
                  // With a zero coefficient only target == base has a solution (sensor 0).
                  if (targetLatched == TEMP_W'(baseLatched)) begin
                     solverBus.exact <= 1'b1;
                  end else begin
                     solverBus.error <= ERR_COEF0;
                  end
                  solverBus.busy <= 1'b0;
                  solverBus.done <= 1'b1;
                  state          <= DONE;
               end else begin
                  rem      <= targetLatched - TEMP_W'(baseLatched);
                  quotient <= '0;
                  state    <= DIVIDE;
               end
            end

            DIVIDE: begin
               if (rem >= TEMP_W'(coefLatched)) begin
                  if (quotient == '1) begin
                     solverBus.error <= ERR_RANGE;
                     solverBus.busy  <= 1'b0;
                     solverBus.done  <= 1'b1;
                     state           <= DONE;
                  end else begin
                     rem      <= rem - TEMP_W'(coefLatched);
                     quotient <= quotient + COEF_W'(1);
                  end
               end else begin
                  // rem < coef here, so it always fits in the narrower remainder field.
                  solverBus.sensorValue <= quotient;
                  solverBus.remainder   <= rem[COEF_W-1:0];
                  solverBus.exact       <= (rem == '0);
                  solverBus.busy        <= 1'b0;
                  solverBus.done        <= 1'b1;
                  state                 <= DONE;
               end
            end

            DONE: begin
               solverBus.done <= 1'b0;
               state          <= IDLE;
            end

            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule
